// File: rtl/rng_pkg.sv
// Shared constants and helpers for the rng block: LFSR width, feedback taps,
// the replacement seed for an all-zero SEED, and the next-state function.
package rng_pkg;

   localparam int          LFSR_W         = 16;
   // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
   localparam logic [15:0] LFSR_TAPS      = 16'hB400;
   localparam logic [15:0] LFSR_SAFE_SEED = 16'h0001;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

   // The all-zero state is a lock-up state for an XOR LFSR, so it is never loaded.
   function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [LFSR_W-1:0] s);
      return (s == '0) ? LFSR_SAFE_SEED : s;
   endfunction

endpackage

// File: rtl/rng_lfsr.sv
// 16-bit Fibonacci LFSR with seed sanitising and synchronous reset.
// Optional RNG_STATE_OUT_EN exposes the registered state for debug.
module rng_lfsr
   import rng_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 16'h0001
) (
   input  logic              clk,
   input  logic              reset,
`ifdef RNG_STATE_OUT_EN
   output logic [LFSR_W-1:0] state,
`endif
   output logic [LFSR_W-1:0] state_d
);

   localparam logic [LFSR_W-1:0] SEED_SAN = lfsr_seed(SEED);

   // Power-up value lets the block run with reset tied low.
   logic [LFSR_W-1:0] lfsr_q = SEED_SAN;

   // The next value is published so the parent can register a function of it
   // on the same edge and stay in lock-step with this register.
   always_comb begin
      state_d = lfsr_next(lfsr_q);
      if (reset) begin
         state_d = SEED_SAN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= SEED_SAN;
      end else begin
         lfsr_q <= state_d;
      end
   end

`ifdef RNG_STATE_OUT_EN
   assign state = lfsr_q;
`endif

endmodule

// File: rtl/rng.sv
// Free-running random number source: LFSR state reduced modulo MAX_VALUE into
// a registered output. RNG_STATE_OUT_EN adds the lfsr_state debug port.
module rng
   import rng_pkg::*;
#(
   parameter int          MAX_VALUE = 32,
   parameter logic [31:0] SEED      = 32'd1,
   localparam int         OUT_W     = $clog2(MAX_VALUE)
) (
   input  logic              clk,
   input  logic              reset,
`ifdef RNG_STATE_OUT_EN
   output logic [LFSR_W-1:0] lfsr_state,
`endif
   output logic [OUT_W-1:0]  random_value
);

   localparam logic [LFSR_W-1:0] SEED_LO  = SEED[LFSR_W-1:0];
   localparam logic [LFSR_W-1:0] SEED_SAN = lfsr_seed(SEED_LO);
   localparam logic [LFSR_W-1:0] MOD      = LFSR_W'(MAX_VALUE);
   localparam logic [OUT_W-1:0]  INIT_RV  = OUT_W'(SEED_SAN % MOD);

   // No handshake: consumers sample random_value whenever they need a value;
   // it changes on every clock edge.
   logic [LFSR_W-1:0] state_d;
   logic [OUT_W-1:0]  rv_d;
   logic [OUT_W-1:0]  rv_q = INIT_RV;

   rng_lfsr #(
      .SEED    (SEED_LO)
   ) u_lfsr (
      .clk     (clk),
      .reset   (reset),
`ifdef RNG_STATE_OUT_EN
      .state   (lfsr_state),
`endif
      .state_d (state_d)
   );

   // Remainder is always below MAX_VALUE, so truncation to OUT_W loses nothing.
   assign rv_d = OUT_W'(state_d % MOD);

   // state_d already selects the seed under reset, so this register tracks
   // the LFSR register with zero latency.
   always_ff @(posedge clk) begin
      rv_q <= rv_d;
   end

   assign random_value = rv_q;

endmodule

// File: tb/tb_rng.sv
// Directed bench for rng: power-up, reset, known sequence, mid-run reset,
// zero seed, full period and a wide-modulus instance against a reference.
module tb_rng;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic reset_off = 1'b0;

   int n_checks = 0;
   int n_fails  = 0;

   logic [4:0] rv_a, rv_b, rv_c, rv_d;
`ifdef RNG_STATE_OUT_EN
   logic [15:0] st_a, st_b, st_c, st_d;
`endif

   // Hand-derived: states 2^i for i = 0..10, then 0x0801; values are state % 18.
   int          exp_val [12] = '{1, 2, 4, 8, 16, 14, 10, 2, 4, 8, 16, 15};
   logic [15:0] exp_st  [12] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008,
                                 16'h0010, 16'h0020, 16'h0040, 16'h0080,
                                 16'h0100, 16'h0200, 16'h0400, 16'h0801};

   always #5 clk = ~clk;

   rng #(.MAX_VALUE(18), .SEED(32'd1)) u_a (
      .clk          (clk),
      .reset        (reset),
`ifdef RNG_STATE_OUT_EN
      .lfsr_state   (st_a),
`endif
      .random_value (rv_a)
   );

   rng #(.MAX_VALUE(18), .SEED(32'd1)) u_b (
      .clk          (clk),
      .reset        (reset_off),
`ifdef RNG_STATE_OUT_EN
      .lfsr_state   (st_b),
`endif
      .random_value (rv_b)
   );

   rng #(.MAX_VALUE(32), .SEED(32'd0)) u_c (
      .clk          (clk),
      .reset        (reset),
`ifdef RNG_STATE_OUT_EN
      .lfsr_state   (st_c),
`endif
      .random_value (rv_c)
   );

   rng #(.MAX_VALUE(32), .SEED(32'h0000ACE1)) u_d (
      .clk          (clk),
      .reset        (reset),
`ifdef RNG_STATE_OUT_EN
      .lfsr_state   (st_d),
`endif
      .random_value (rv_d)
   );

   function automatic logic [15:0] ref_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_no_reset();
      #1;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) step();
         n_checks++;
         if (rv_b !== 5'(exp_val[i])) begin
            n_fails++;
            $display("FAIL no_reset step %0d: got %0d expected %0d", i, rv_b, exp_val[i]);
         end
`ifdef RNG_STATE_OUT_EN
         n_checks++;
         if (st_b !== exp_st[i]) begin
            n_fails++;
            $display("FAIL no_reset_state step %0d: got %h expected %h", i, st_b, exp_st[i]);
         end
`endif
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (rv_a !== 5'd1 || rv_c !== 5'd1 || rv_d !== 5'd1) begin
            n_fails++;
            $display("FAIL reset_hold cycle %0d: got a=%0d c=%0d d=%0d expected 1 1 1",
                     i, rv_a, rv_c, rv_d);
         end
`ifdef RNG_STATE_OUT_EN
         n_checks++;
         if (st_a !== 16'h0001 || st_c !== 16'h0001 || st_d !== 16'hACE1) begin
            n_fails++;
            $display("FAIL reset_state cycle %0d: got a=%h c=%h d=%h expected 0001 0001 ace1",
                     i, st_a, st_c, st_d);
         end
`endif
      end
   endtask

   task automatic check_sequence(input string tag);
      for (int i = 1; i < 12; i++) begin
         step();
         n_checks++;
         if (rv_a !== 5'(exp_val[i])) begin
            n_fails++;
            $display("FAIL %s step %0d: got %0d expected %0d", tag, i, rv_a, exp_val[i]);
         end
`ifdef RNG_STATE_OUT_EN
         n_checks++;
         if (st_a !== exp_st[i]) begin
            n_fails++;
            $display("FAIL %s_state step %0d: got %h expected %h", tag, i, st_a, exp_st[i]);
         end
`endif
      end
   endtask

   task automatic test_sequence();
      reset = 1'b0;
      check_sequence("sequence");
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 40; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_checks++;
      if (rv_a !== 5'd1) begin
         n_fails++;
         $display("FAIL mid_reset: got %0d expected 1", rv_a);
      end
`ifdef RNG_STATE_OUT_EN
      n_checks++;
      if (st_a !== 16'h0001) begin
         n_fails++;
         $display("FAIL mid_reset_state: got %h expected 0001", st_a);
      end
`endif
      check_sequence("after_mid_reset");
   endtask

   task automatic test_period();
      logic [15:0] m_a, m_c, m_d;
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_a = 16'h0001;
      m_c = 16'h0001;
      m_d = 16'hACE1;
      for (int cyc = 1; cyc <= 65535; cyc++) begin
         step();
         m_a = ref_step(m_a);
         m_c = ref_step(m_c);
         m_d = ref_step(m_d);
         n_checks++;
         if (rv_a !== 5'(m_a % 16'd18) || !(rv_a < 5'd18)) begin
            n_fails++;
            if (n_fails < 20) $display("FAIL period_mod18 cycle %0d: got %0d expected %0d",
                                       cyc, rv_a, m_a % 16'd18);
         end
         n_checks++;
         if (rv_c !== m_c[4:0]) begin
            n_fails++;
            if (n_fails < 20) $display("FAIL zero_seed cycle %0d: got %0d expected %0d",
                                       cyc, rv_c, m_c[4:0]);
         end
         n_checks++;
         if (rv_d !== m_d[4:0]) begin
            n_fails++;
            if (n_fails < 20) $display("FAIL seed_ace1 cycle %0d: got %0d expected %0d",
                                       cyc, rv_d, m_d[4:0]);
         end
`ifdef RNG_STATE_OUT_EN
         n_checks++;
         if (st_a !== m_a || st_c !== m_c || st_c === 16'h0000 || st_d !== m_d) begin
            n_fails++;
            if (n_fails < 20) $display("FAIL period_state cycle %0d: got %h %h %h expected %h %h %h",
                                       cyc, st_a, st_c, st_d, m_a, m_c, m_d);
         end
`endif
      end
      // After exactly 65535 steps the generator is back at its seed.
      n_checks++;
      if (rv_a !== 5'd1 || rv_d !== 5'd1) begin
         n_fails++;
         $display("FAIL period_return: got a=%0d d=%0d expected 1 1", rv_a, rv_d);
      end
`ifdef RNG_STATE_OUT_EN
      n_checks++;
      if (st_a !== 16'h0001 || st_d !== 16'hACE1) begin
         n_fails++;
         $display("FAIL period_return_state: got %h %h expected 0001 ace1", st_a, st_d);
      end
`endif
      check_sequence("second_period");
   endtask

   initial begin
      reset = 1'b1;
      reset_off = 1'b0;
      test_no_reset();
      test_reset();
      test_sequence();
      test_mid_reset();
      test_period();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/rng.md
# rng

Free-running pseudo-random number generator producing a uniform-ish integer in [0, MAX_VALUE-1] every clock cycle. Built from a 16-bit maximal-length Fibonacci LFSR whose state is reduced modulo MAX_VALUE into a registered output. Used by game/control logic as a cheap random source; it has no handshake, and consumers sample `random_value` whenever they need a value.

## Interface
- `MAX_VALUE`, default 32: number of distinct output values; output range 0..MAX_VALUE-1; legal range 2..65535.
- `SEED`, default 1: 16-bit LFSR load value at power-up and reset; a SEED whose low 16 bits are 0 is replaced by 16'h0001.
- `clk`  input  1  rising-edge clock; single clock domain.
- `reset`  input  1  synchronous, active-high reset.
- `random_value`  output  $clog2(MAX_VALUE)  current random number; 5 bits for MAX_VALUE 18 or 32.

## Operation
- State: `lfsr[15:0]`. Feedback `fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]` (x^16+x^14+x^13+x^11+1); next = {lfsr[14:0], fb}. Period 65535; the all-zero state is never entered.
- `random_value` = lfsr % MAX_VALUE, at all times consistent with the current `lfsr` register. Next-state and its modulo are computed combinationally, and both are registered on the same edge.
- Modulo: constant-divisor `%` on 16 bits; result truncated to output width, which is lossless because the result is < MAX_VALUE.
- Power-up: both registers carry initial values (`lfsr`=SEED, `random_value`=SEED % MAX_VALUE). The block runs correctly with `reset` tied 0 or left unconnected (treated as deasserted).
- No enable: the state advances every cycle when `reset`=0.

## Timing
- Reset: on the edge where `reset`=1, `lfsr`<=SEED (sanitised) and `random_value`<=SEED % MAX_VALUE. Reset held for several cycles keeps both values constant.
- First edge with `reset`=0 loads step 1 of the sequence. Latency from state to output is 0 cycles, because both update on the same edge.
- Reset asserted mid-sequence: the sequence restarts from SEED on that edge. The outcome is deterministic and independent of prior state.

## Configuration
- `RNG_STATE_OUT_EN` defined: adds output port `lfsr_state` (output, 16 bits) equal to the `lfsr` register, for debug and verification.
- `RNG_STATE_OUT_EN` undefined: the port is absent, and functional behaviour is otherwise identical.

## Structure
- Shared package `rng_pkg`:
  - `LFSR_W`=16
  - tap mask 16'hB400
  - `LFSR_SAFE_SEED`=16'h0001
  - function `lfsr_next(logic [15:0])`
- One sub-module is natural: `rng_lfsr`, which holds the LFSR register, seed sanitising and reset. Top-level `rng` adds the modulo reduction and the output register.
- Output width is a localparam `OUT_W = $clog2(MAX_VALUE)`.

## Test plan
- MAX_VALUE=18, SEED=1, reset one cycle, then free-run:
  - `random_value` sequence is 1,2,4,8,16,14,10,2,4,8,16,15.
  - Corresponding `lfsr` states are 0x0001…0x0400, then 0x0801.
- Reset pulsed after 40 cycles: on the following edge `random_value`=1 and `lfsr`=0x0001, and the sequence above repeats exactly.
- No reset ever asserted (reset=0 from t=0): output starts at 1 and follows the same sequence; no X values appear on `random_value`.
- SEED=0, MAX_VALUE=32: after reset `lfsr`=0x0001 and `random_value`=1; the state never becomes 0x0000 over 70000 cycles.
- MAX_VALUE=18, 65535 cycles: every sample is < 18, and the state returns to SEED exactly at cycle 65535 (period check).
- MAX_VALUE=32, SEED=16'hACE1:
  - `random_value` always equals `lfsr[4:0]`, checked against a reference model every cycle.
  - With `RNG_STATE_OUT_EN`, `lfsr_state` matches the model.
